bcd_7seg_scan: RTL and testbench

//  Downstream display stage for the serial binary-to-BCD converter. Captures a 3-digit packed
//  BCD word {hundreds[1:0], tens[3:0], ones[3:0]} on a load strobe into a shadow register.

---
 rtl/bcd_7seg_scan.sv | 137 +++++++++++++
 tb/tb_bcd_7seg_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_7seg_scan
//   Display stage behind the serial binary-to-BCD converter. A 3-digit packed
//   BCD word is captured into a shadow register on load_i. The three digits
//   are then time-multiplexed onto one 7-segment bus. Each digit slot lasts
//   REFRESH_DIV cycles: one blank cycle against ghosting, then lit cycles.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     When defined, leading zero digits (hundreds, then tens) are blanked.
//
// Ports
//   clk_i    in   1   clock, rising edge
//   rst_n_i  in   1   asynchronous active-low reset
//   bcd_i    in   10  {hund[9:8], tens[7:4], ones[3:0]}
//   load_i   in   1   capture bcd_i into the shadow register
//   seg_o    out  7   {g,f,e,d,c,b,a}, active-high, registered
//   an_o     out  3   active-low digit enables {hund,tens,ones}, registered
//   frame_o  out  1   one-cycle pulse per full 3-digit scan, registered
// ---------------------------------------------------------------------------
module bcd_7seg_scan #(
    parameter int REFRESH_DIV = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [9:0] bcd_i,
    input  logic       load_i,
    output logic [6:0] seg_o,
    output logic [2:0] an_o,
    output logic       frame_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [9:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic             frame_q, frame_d;

    logic [3:0]       digit;
    logic             slot_blank;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h40;  // non-BCD nibble shows a dash
        endcase
    endfunction

    // Shadow capture: a load always wins, regardless of scan position.
    always_comb begin
        shadow_d = load_i ? bcd_i : shadow_q;
    end

    // Refresh counter and digit index.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (idx_q)
                2'd0:    idx_d = 2'd1;
                2'd1:    idx_d = 2'd2;
                default: idx_d = 2'd0;  // also recovers from stray idx 3
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Digit selection from the shadow, plus optional leading-zero blanking.
    always_comb begin
        digit      = 4'd0;
        slot_blank = 1'b0;
        case (idx_q)
            2'd0: digit = shadow_q[3:0];
            2'd1: begin
                digit = shadow_q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
                slot_blank = (shadow_q[9:8] == 2'd0) && (shadow_q[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                digit = {2'b00, shadow_q[9:8]};
`ifdef LEADING_ZERO_BLANK_EN
                slot_blank = (shadow_q[9:8] == 2'd0);
`endif
            end
            default: slot_blank = 1'b1;  // unreachable index stays dark
        endcase
    end

    // Output register inputs, from pre-edge cnt/idx/shadow.
    always_comb begin
        an_d    = 3'b111;
        seg_d   = 7'h00;
        frame_d = (cnt_q == CNT_LAST) && (idx_q == 2'd2);
        if ((cnt_q != '0) && !slot_blank) begin
            an_d  = ~(3'b001 << idx_q);
            seg_d = enc(digit);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= 7'h00;
            an_q     <= 3'b111;
            frame_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_7seg_scan
//   Directed bench for bcd_7seg_scan at REFRESH_DIV=4. A cycle-position model
//   (elapsed edges since reset -> slot/digit by division) predicts every
//   output each cycle; literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_bcd_7seg_scan;

    localparam int RD = 4;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [9:0] bcd_i;
    logic       load_i;
    logic [6:0] seg_o;
    logic [2:0] an_o;
    logic       frame_o;

    int checks   = 0;
    int failures = 0;

    bcd_7seg_scan #(.REFRESH_DIV(RD), .CNT_W(2)) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bcd_i  (bcd_i),
        .load_i (load_i),
        .seg_o  (seg_o),
        .an_o   (an_o),
        .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model: position = edges since reset release; slot and digit by arithmetic.
    int         pos;
    int         msh;
    logic [6:0] e_seg;
    logic [2:0] e_an;
    logic       e_fr;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pos   <= 0;
            msh   <= 0;
            e_seg <= 7'h00;
            e_an  <= 3'b111;
            e_fr  <= 1'b0;
        end else begin
            automatic int  slot  = pos % RD;
            automatic int  dig   = (pos / RD) % 3;
            automatic int  val   = (msh >> (4 * dig)) & 15;
            automatic bit  blank = (slot == 0);
`ifdef LEADING_ZERO_BLANK_EN
            if (dig == 2 && msh / 256 == 0) blank = 1'b1;
            if (dig == 1 && msh / 16 == 0)  blank = 1'b1;
`endif
            e_fr  <= ((pos % (3 * RD)) == 3 * RD - 1);
            e_an  <= blank ? 3'b111 : (3'b111 & ~(3'b001 << dig));
            e_seg <= blank ? 7'h00 : SEG_TAB[val];
            pos   <= pos + 1;
            if (load_i) msh <= int'(bcd_i);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_i) begin
        checks++;
        if (an_o !== e_an || seg_o !== e_seg || frame_o !== e_fr) begin
            failures++;
            $display("FAIL model t=%0t an=%b seg=%h fr=%b expected an=%b seg=%h fr=%b",
                     $time, an_o, seg_o, frame_o, e_an, e_seg, e_fr);
        end
    end

    task automatic chk(input string name, input logic [2:0] an,
                       input logic [6:0] seg, input logic fr);
        checks++;
        if (an_o !== an || seg_o !== seg || frame_o !== fr) begin
            failures++;
            $display("FAIL %s an=%b seg=%h fr=%b expected an=%b seg=%h fr=%b",
                     name, an_o, seg_o, frame_o, an, seg, fr);
        end
    endtask

    // Advance one cycle; ends just after the falling edge so outputs are settled.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    task automatic load(input logic [9:0] v);
        bcd_i  = v;
        load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    // Leaves the bench on the cycle frame_o is seen high (last hundreds lit cycle).
    task automatic wait_frame(input string name);
        int n = 0;
        while (frame_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (frame_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s frame timeout fr=%b expected fr=1", name, frame_o);
        end
    endtask

    logic [2:0] pat_an  [0:11];
    logic [6:0] pat_seg [0:11];

    initial begin
        rst_n_i = 1'b0;
        bcd_i   = '0;
        load_i  = 1'b0;
        repeat (3) step();
        chk("reset_hold", 3'b111, 7'h00, 1'b0);
        rst_n_i = 1'b1;
        step();
        chk("rel_edge1", 3'b111, 7'h00, 1'b0);
        step();
        chk("rel_edge2", 3'b110, 7'h3F, 1'b0);

        // 235: full scan pattern after a frame pulse.
        load(10'h235);
        wait_frame("p235");
        pat_an  = '{3'b111, 3'b110, 3'b110, 3'b110, 3'b111, 3'b101,
                    3'b101, 3'b101, 3'b111, 3'b011, 3'b011, 3'b011};
        pat_seg = '{7'h00, 7'h6D, 7'h6D, 7'h6D, 7'h00, 7'h4F,
                    7'h4F, 7'h4F, 7'h00, 7'h5B, 7'h5B, 7'h5B};
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("p235_%0d", i), pat_an[i], pat_seg[i], i == 11);
        end

        // 2AF: non-BCD nibbles display a dash.
        load(10'h2AF);
        wait_frame("p2af");
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 1)  chk("p2af_ones", 3'b110, 7'h40, 1'b0);
            if (i == 5)  chk("p2af_tens", 3'b101, 7'h40, 1'b0);
            if (i == 9)  chk("p2af_hund", 3'b011, 7'h5B, 1'b0);
        end

        // 007: leading zeros.
        load(10'h007);
        wait_frame("p007");
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 1) chk("p007_ones", 3'b110, 7'h07, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
            if (i == 5) chk("p007_tens", 3'b111, 7'h00, 1'b0);
            if (i == 9) chk("p007_hund", 3'b111, 7'h00, 1'b0);
`else
            if (i == 5) chk("p007_tens", 3'b101, 7'h3F, 1'b0);
            if (i == 9) chk("p007_hund", 3'b011, 7'h3F, 1'b0);
`endif
        end

        // Load 100 during the lit ones slot while 235 is displayed.
        load(10'h235);
        wait_frame("p100");
        step();
        chk("p100_blank", 3'b111, 7'h00, 1'b0);
        step();
        chk("p100_lit1", 3'b110, 7'h6D, 1'b0);
        load(10'h100);
        chk("p100_lit2", 3'b110, 7'h6D, 1'b0);
        step();
        chk("p100_lit3", 3'b110, 7'h3F, 1'b0);
        step();
        step();
        chk("p100_tens", 3'b101, 7'h3F, 1'b0);
        repeat (4) step();
        chk("p100_hund", 3'b011, 7'h06, 1'b0);

        // Reset pulse mid tens slot.
        load(10'h235);
        wait_frame("prst");
        repeat (6) step();
        chk("prst_tens", 3'b101, 7'h4F, 1'b0);
        rst_n_i = 1'b0;
        #1;
        chk("prst_async", 3'b111, 7'h00, 1'b0);
        step();
        rst_n_i = 1'b1;
        step();
        chk("prst_edge1", 3'b111, 7'h00, 1'b0);
        step();
        chk("prst_edge2", 3'b110, 7'h3F, 1'b0);
        repeat (14) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
